// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the BRAM-backed SDRAM responder.
// Holds the SDRAM bus widths, the burst length, the responder state
// encoding, the captured-request record and the line-wrap address helper.
package sdram_pkg;

  localparam int SDRAM_ID_W   = 3;
  localparam int SDRAM_ADDR_W = 26;
  localparam int SDRAM_DATA_W = 32;
  localparam int BURST_WORDS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2,
    READ  = 2'd3
  } resp_state_e;

  typedef struct packed {
    logic [SDRAM_ID_W-1:0]   id;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic                    write;
    logic                    burst;
    logic [3:0]              wstrb;
    logic [SDRAM_DATA_W-1:0] wdata;
  } sdram_req_t;

  // Byte address of word k of a critical-word-first burst: the 64-byte line
  // is held and the word offset wraps modulo 16 (4-bit add overflows).
  function automatic logic [SDRAM_ADDR_W-1:0] wrap_addr(
    input logic [SDRAM_ADDR_W-1:2] base_word,
    input logic [3:0]              k
  );
    return {base_word[SDRAM_ADDR_W-1:6], base_word[5:2] + k, 2'b00};
  endfunction

endpackage

// File: rtl/sdram_bram_responder_bram.sv
// bram_bytewise: single-port RAM, 32-bit words, synchronous read, per-byte
// write enables. The read register only updates on a read, so it holds the
// last word returned between reads.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset of the read register
//   we     in  4 byte write enables (byte b = wdata[8b+7:8b])
//   re     in  read enable
//   addr   in  word address
//   wdata  in  write data
//   rdata  out registered read data
module bram_bytewise #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Byte-wise RAM write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Next read-register value: new word on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_bram_responder.sv
// sdram_bram_responder: memory-side responder for the SDRAM request/response
// bus, backed by on-chip block RAM, with emulated read latency.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   sdram_request  in  [2:0]  master ID of the presented request (0 = none)
//   sdram_ready    out        request accepted this cycle when request != 0
//   sdram_address  in  [25:0] byte address
//   sdram_write    in         1 = write, 0 = read
//   sdram_burst    in         1 = 16-word read burst
//   sdram_wstrb    in  [3:0]  write byte enables
//   sdram_wdata    in  [31:0] write data
//   sdram_raddress out [25:0] byte address of the returned word
//   sdram_rdata    out [31:0] returned word
//   sdram_rvalid   out [2:0]  owning master ID of the returned word (0 = none)
//   sdram_complete out        last word of the read transaction
module sdram_bram_responder
  import sdram_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 14,
  parameter int READ_LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SDRAM_ID_W-1:0]   sdram_request,
  output logic                    sdram_ready,
  input  logic [SDRAM_ADDR_W-1:0] sdram_address,
  input  logic                    sdram_write,
  input  logic                    sdram_burst,
  input  logic [3:0]              sdram_wstrb,
  input  logic [SDRAM_DATA_W-1:0] sdram_wdata,
  output logic [SDRAM_ADDR_W-1:0] sdram_raddress,
  output logic [SDRAM_DATA_W-1:0] sdram_rdata,
  output logic [SDRAM_ID_W-1:0]   sdram_rvalid,
  output logic                    sdram_complete
);

  // The RAM read register adds one cycle, so the first read is issued at
  // accept + READ_LATENCY - 1; WAIT therefore counts READ_LATENCY - 2 down.
  localparam logic [3:0] WAIT_LOAD = 4'(READ_LATENCY - 2);

  resp_state_e             state_q, state_d;
  sdram_req_t              req_q, req_d;
  logic                    ready_q, ready_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [4:0]              word_cnt_q, word_cnt_d;
  logic [SDRAM_ID_W-1:0]   rvalid_q, rvalid_d;
  logic                    complete_q, complete_d;
  logic [SDRAM_ADDR_W-1:0] raddress_q, raddress_d;

  logic                    issue_s;
  logic [4:0]              words_total_s;
  logic [SDRAM_ADDR_W-1:0] word_addr_s;
  logic [3:0]              ram_we_s;
  logic                    ram_re_s;
  logic [SDRAM_DATA_W-1:0] ram_rdata_s;
  logic                    unused_addr_lsb_s;

  assign words_total_s     = req_q.burst ? 5'd16 : 5'd1;
  assign word_addr_s       = wrap_addr(req_q.addr[SDRAM_ADDR_W-1:2], word_cnt_q[3:0]);
  assign unused_addr_lsb_s = ^req_q.addr[1:0];

  // Next-state, counters and registered response outputs.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ready_d    = ready_q;
    wait_cnt_d = wait_cnt_q;
    word_cnt_d = word_cnt_q;
    rvalid_d   = {SDRAM_ID_W{1'b0}};
    complete_d = 1'b0;
    raddress_d = raddress_q;
    ram_we_s   = 4'b0000;
    ram_re_s   = 1'b0;
    issue_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_q && (sdram_request != {SDRAM_ID_W{1'b0}})) begin
          req_d      = '{id: sdram_request, addr: sdram_address, write: sdram_write,
                         burst: sdram_burst, wstrb: sdram_wstrb, wdata: sdram_wdata};
          ready_d    = 1'b0;
          wait_cnt_d = WAIT_LOAD;
          word_cnt_d = 5'd0;
          state_d    = sdram_write ? WRITE : WAIT;
        end else begin
          ready_d = 1'b1;
        end
      end
      WRITE: begin
        ram_we_s = req_q.wstrb;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          issue_s = 1'b1;
          state_d = READ;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      READ: begin
        // All words issued: the last one is on the outputs this cycle.
        if (word_cnt_q == words_total_s) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          issue_s = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A read issued now has its data in the RAM register next cycle, which
    // lines up with the registered rvalid/raddress/complete.
    if (issue_s) begin
      ram_re_s   = 1'b1;
      rvalid_d   = req_q.id;
      complete_d = (word_cnt_q == (words_total_s - 5'd1));
      raddress_d = word_addr_s;
      word_cnt_d = word_cnt_q + 5'd1;
    end else begin
      ram_re_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      ready_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
      word_cnt_q <= 5'd0;
      rvalid_q   <= {SDRAM_ID_W{1'b0}};
      complete_q <= 1'b0;
      raddress_q <= {SDRAM_ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ready_q    <= ready_d;
      wait_cnt_q <= wait_cnt_d;
      word_cnt_q <= word_cnt_d;
      rvalid_q   <= rvalid_d;
      complete_q <= complete_d;
      raddress_q <= raddress_d;
    end
  end

  bram_bytewise #(
    .DEPTH_LOG2(ADDR_WORDS_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (word_addr_s[ADDR_WORDS_LOG2+1:2]),
    .wdata (req_q.wdata),
    .rdata (ram_rdata_s)
  );

  assign sdram_ready    = ready_q;
  assign sdram_rvalid   = rvalid_q;
  assign sdram_complete = complete_q;
  assign sdram_raddress = raddress_q;
  assign sdram_rdata    = ram_rdata_s;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder (ADDR_WORDS_LOG2=14, READ_LATENCY=4).
module tb_sdram_bram_responder;
  import sdram_pkg::*;

  localparam int AWL = 14;
  localparam int LAT = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  sdram_request;
  logic        sdram_ready;
  logic [25:0] sdram_address;
  logic        sdram_write;
  logic        sdram_burst;
  logic [3:0]  sdram_wstrb;
  logic [31:0] sdram_wdata;
  logic [25:0] sdram_raddress;
  logic [31:0] sdram_rdata;
  logic [2:0]  sdram_rvalid;
  logic        sdram_complete;

  int total;
  int bad;

  // captured read responses (cycle counted from the accept cycle = 0)
  int          n_rx;
  int          rdy_cyc;
  int          rx_cyc  [0:31];
  logic [31:0] rx_data [0:31];
  logic [25:0] rx_addr [0:31];
  logic [2:0]  rx_id   [0:31];
  logic        rx_cmp  [0:31];
  int          wr_rdy_cyc;
  int          wr_rv_seen;

  sdram_bram_responder #(
    .ADDR_WORDS_LOG2(AWL),
    .READ_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sdram_request  (sdram_request),
    .sdram_ready    (sdram_ready),
    .sdram_address  (sdram_address),
    .sdram_write    (sdram_write),
    .sdram_burst    (sdram_burst),
    .sdram_wstrb    (sdram_wstrb),
    .sdram_wdata    (sdram_wdata),
    .sdram_raddress (sdram_raddress),
    .sdram_rdata    (sdram_rdata),
    .sdram_rvalid   (sdram_rvalid),
    .sdram_complete (sdram_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] id, input logic [25:0] a, input logic wr,
                       input logic bu, input logic [3:0] st, input logic [31:0] wd);
    sdram_request = id;
    sdram_address = a;
    sdram_write   = wr;
    sdram_burst   = bu;
    sdram_wstrb   = st;
    sdram_wdata   = wd;
  endtask

  // Called at a negedge; returns at a negedge with ready high, or flags a timeout.
  task automatic wait_ready();
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (sdram_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) begin
      total++;
      bad++;
      $display("FAIL wait_ready: ready=%b after 100 cycles, required 1", sdram_ready);
    end
  endtask

  task automatic do_write(input logic [2:0] id, input logic [25:0] a,
                          input logic [31:0] d, input logic [3:0] st);
    wait_ready();
    drive(id, a, 1'b1, 1'b0, st, d);
    @(posedge clk);
    wr_rdy_cyc = -1;
    wr_rv_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) sdram_request = 3'd0;
      if (sdram_rvalid !== 3'd0) wr_rv_seen = 1;
      if (sdram_ready === 1'b1) begin
        wr_rdy_cyc = c;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [2:0] id, input logic [25:0] a, input logic bu);
    wait_ready();
    drive(id, a, 1'b0, bu, 4'b0000, 32'h0000_0000);
    @(posedge clk);
    n_rx    = 0;
    rdy_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) sdram_request = 3'd0;
      if (sdram_rvalid !== 3'd0) begin
        if (n_rx < 32) begin
          rx_cyc[n_rx]  = c;
          rx_data[n_rx] = sdram_rdata;
          rx_addr[n_rx] = sdram_raddress;
          rx_id[n_rx]   = sdram_rvalid;
          rx_cmp[n_rx]  = sdram_complete;
        end
        n_rx++;
      end
      if (sdram_ready === 1'b1) begin
        rdy_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (sdram_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", sdram_ready); end
    total++; if (sdram_rvalid !== 3'd0) begin bad++; $display("FAIL rst_rvalid: got %0d want 0", sdram_rvalid); end
    total++; if (sdram_complete !== 1'b0) begin bad++; $display("FAIL rst_complete: got %b want 0", sdram_complete); end
    total++; if (sdram_raddress !== 26'h0) begin bad++; $display("FAIL rst_raddress: got %h want 0", sdram_raddress); end
    total++; if (sdram_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", sdram_rdata); end
    reset_n = 1'b1;
    #1;
    total++; if (sdram_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready: got %b want 0", sdram_ready); end
    @(negedge clk);
    total++; if (sdram_ready !== 1'b1) begin bad++; $display("FAIL rst_first_edge_ready: got %b want 1", sdram_ready); end
  endtask

  task automatic test_single_read();
    do_write(3'd1, 26'h000100, 32'hDEADBEEF, 4'b1111);
    total++; if (wr_rdy_cyc !== 2) begin bad++; $display("FAIL wr_ready_cycle: got %0d want 2", wr_rdy_cyc); end
    total++; if (wr_rv_seen !== 0) begin bad++; $display("FAIL wr_no_rvalid: got %0d want 0", wr_rv_seen); end
    do_read(3'd2, 26'h000100, 1'b0);
    total++; if (n_rx !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", n_rx); end
    total++; if (rx_cyc[0] !== LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", rx_cyc[0], LAT); end
    total++; if (rx_id[0] !== 3'd2) begin bad++; $display("FAIL single_id: got %0d want 2", rx_id[0]); end
    total++; if (rx_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", rx_data[0]); end
    total++; if (rx_addr[0] !== 26'h000100) begin bad++; $display("FAIL single_raddr: got %h want 000100", rx_addr[0]); end
    total++; if (rx_cmp[0] !== 1'b1) begin bad++; $display("FAIL single_complete: got %b want 1", rx_cmp[0]); end
    total++; if (rdy_cyc !== LAT + 1) begin bad++; $display("FAIL single_ready_back: got %0d want %0d", rdy_cyc, LAT + 1); end
    // after the read, outputs are idle but data/address hold
    @(negedge clk);
    total++; if (sdram_rvalid !== 3'd0 || sdram_complete !== 1'b0) begin bad++; $display("FAIL single_idle_out: rvalid=%0d complete=%b want 0/0", sdram_rvalid, sdram_complete); end
    total++; if (sdram_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold_data: got %h want deadbeef", sdram_rdata); end
  endtask

  task automatic test_byte_strobe();
    do_write(3'd1, 26'h000200, 32'h11223344, 4'b1111);
    do_write(3'd1, 26'h000200, 32'hAABBCCDD, 4'b0101);
    do_read(3'd4, 26'h000200, 1'b0);
    total++; if (n_rx !== 1 || rx_data[0] !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_data: n=%0d got %h want 11bb33dd", n_rx, rx_data[0]); end
    do_write(3'd6, 26'h000200, 32'hFFFFFFFF, 4'b0000);
    total++; if (wr_rdy_cyc !== 2) begin bad++; $display("FAIL strobe0_ready: got %0d want 2", wr_rdy_cyc); end
    do_read(3'd6, 26'h000200, 1'b0);
    total++; if (n_rx !== 1 || rx_data[0] !== 32'h11BB33DD || rx_id[0] !== 3'd6) begin bad++; $display("FAIL strobe0_data: n=%0d id=%0d got %h want 6/11bb33dd", n_rx, rx_id[0], rx_data[0]); end
  endtask

  task automatic test_burst();
    int off;
    for (int i = 0; i < 16; i++) begin
      do_write(3'd2, 26'h000400 + 26'(i * 4), 32'(i), 4'b1111);
    end
    do_read(3'd3, 26'h000428, 1'b1);
    total++; if (n_rx !== 16) begin bad++; $display("FAIL burst_count: got %0d want 16", n_rx); end
    for (int k = 0; k < 16 && k < n_rx; k++) begin
      off = (10 + k) % 16;
      total++; if (rx_cyc[k] !== LAT + k) begin bad++; $display("FAIL burst_cycle[%0d]: got %0d want %0d", k, rx_cyc[k], LAT + k); end
      total++; if (rx_data[k] !== 32'(off)) begin bad++; $display("FAIL burst_data[%0d]: got %h want %h", k, rx_data[k], off); end
      total++; if (rx_addr[k] !== 26'h000400 + 26'(off * 4)) begin bad++; $display("FAIL burst_raddr[%0d]: got %h want %h", k, rx_addr[k], 26'h000400 + 26'(off * 4)); end
      total++; if (rx_id[k] !== 3'd3) begin bad++; $display("FAIL burst_id[%0d]: got %0d want 3", k, rx_id[k]); end
      total++; if (rx_cmp[k] !== (k == 15)) begin bad++; $display("FAIL burst_complete[%0d]: got %b want %b", k, rx_cmp[k], (k == 15)); end
    end
    total++; if (rdy_cyc !== LAT + 16) begin bad++; $display("FAIL burst_ready_back: got %0d want %0d", rdy_cyc, LAT + 16); end
  endtask

  task automatic test_back_to_back();
    int acc2, rv1_cyc, rv5_cyc, nrv;
    logic [31:0] d1, d5;
    acc2 = -1; rv1_cyc = -1; rv5_cyc = -1; nrv = 0; d1 = 32'h0; d5 = 32'h0;
    wait_ready();
    drive(3'd1, 26'h000100, 1'b0, 1'b0, 4'b0000, 32'h0);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) drive(3'd5, 26'h000200, 1'b0, 1'b0, 4'b0000, 32'h0);
      else if (acc2 >= 0 && c == acc2 + 1) sdram_request = 3'd0;
      if (sdram_rvalid === 3'd1) begin
        if (rv1_cyc < 0) begin rv1_cyc = c; d1 = sdram_rdata; end
        nrv++;
      end else if (sdram_rvalid === 3'd5) begin
        if (rv5_cyc < 0) begin rv5_cyc = c; d5 = sdram_rdata; end
        nrv++;
      end else if (sdram_rvalid !== 3'd0) begin
        nrv += 100;
      end
      if (acc2 < 0 && sdram_ready === 1'b1) acc2 = c;
      else if (acc2 >= 0 && c > acc2 && sdram_ready === 1'b1) break;
    end
    sdram_request = 3'd0;
    total++; if (rv1_cyc !== LAT) begin bad++; $display("FAIL b2b_first_cycle: got %0d want %0d", rv1_cyc, LAT); end
    total++; if (acc2 !== LAT + 1) begin bad++; $display("FAIL b2b_second_accept: got %0d want %0d", acc2, LAT + 1); end
    total++; if (rv5_cyc !== 2 * LAT + 1) begin bad++; $display("FAIL b2b_second_cycle: got %0d want %0d", rv5_cyc, 2 * LAT + 1); end
    total++; if (nrv !== 2) begin bad++; $display("FAIL b2b_word_count: got %0d want 2", nrv); end
    total++; if (d1 !== 32'hDEADBEEF || d5 !== 32'h11BB33DD) begin bad++; $display("FAIL b2b_data: got %h/%h want deadbeef/11bb33dd", d1, d5); end
  endtask

  task automatic test_reset_mid_burst();
    int nw, hit, quiet_bad;
    logic [31:0] d5;
    nw = 0; hit = 0; quiet_bad = 0; d5 = 32'h0;
    wait_ready();
    drive(3'd3, 26'h000400, 1'b0, 1'b1, 4'b0000, 32'h0);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) sdram_request = 3'd0;
      if (sdram_rvalid !== 3'd0) nw++;
      if (nw == 5) begin
        hit = 1;
        d5 = sdram_rdata;
        break;
      end
    end
    total++; if (hit !== 1 || d5 !== 32'h4) begin bad++; $display("FAIL mid_fifth_word: seen=%0d got %h want 4", hit, d5); end
    reset_n = 1'b0;
    #1;
    total++; if (sdram_rvalid !== 3'd0) begin bad++; $display("FAIL mid_rst_rvalid: got %0d want 0", sdram_rvalid); end
    total++; if (sdram_complete !== 1'b0) begin bad++; $display("FAIL mid_rst_complete: got %b want 0", sdram_complete); end
    total++; if (sdram_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", sdram_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sdram_rvalid !== 3'd0) quiet_bad++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        total++; if (sdram_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", sdram_ready); end
      end
      if (sdram_rvalid !== 3'd0) quiet_bad++;
      @(negedge clk);
    end
    total++; if (quiet_bad !== 0) begin bad++; $display("FAIL mid_no_more_words: got %0d words want 0", quiet_bad); end
    do_read(3'd2, 26'h000100, 1'b0);
    total++; if (n_rx !== 1 || rx_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_reread: n=%0d got %h want deadbeef", n_rx, rx_data[0]); end
  endtask

  task automatic test_alias();
    logic [25:0] alias_a;
    alias_a = 26'd1 << (AWL + 2);
    do_write(3'd1, 26'h000000, 32'hCAFEF00D, 4'b1111);
    do_read(3'd7, alias_a, 1'b0);
    total++; if (n_rx !== 1 || rx_data[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_data: n=%0d got %h want cafef00d", n_rx, rx_data[0]); end
    total++; if (rx_id[0] !== 3'd7) begin bad++; $display("FAIL alias_id7: got %0d want 7", rx_id[0]); end
    total++; if (rx_addr[0] !== alias_a) begin bad++; $display("FAIL alias_raddr: got %h want %h", rx_addr[0], alias_a); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rx  = 0;
    rdy_cyc = -1;
    wr_rdy_cyc = -1;
    wr_rv_seen = 0;
    reset_n = 1'b0;
    drive(3'd0, 26'h0, 1'b0, 1'b0, 4'b0000, 32'h0);
    test_reset();
    test_single_read();
    test_byte_strobe();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_alias();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_bram_responder.md
Name: sdram_bram_responder

Overview:
- Memory-side responder for the SDRAM request/response bus driven by the SDRAM arbiter (sdram_request/ready/address/write/burst/wstrb/wdata, and sdram_raddress/rdata/rvalid/complete back).
- Backs the bus with on-chip block RAM and emulates SDRAM read latency with a programmable wait.
- Used in simulation and in small FPGA builds without external SDRAM; it replaces the SDRAM controller with no change to the arbiter or the masters.

Parameters:
ADDR_WORDS_LOG2, 14, log2 of RAM depth in 32-bit words; upper address bits ignored (aliasing).
READ_LATENCY, 4, cycles from accept cycle to first rvalid (legal range 2..15).
BURST_WORDS, 16, words per burst (64 bytes); fixed by protocol.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
sdram_request  in  3  master ID of the presented request; 0 means no request.
sdram_ready  out  1  responder accepts the presented request this cycle.
sdram_address  in  26  byte address of the request; bits [1:0] ignored.
sdram_write  in  1  1 = write, 0 = read.
sdram_burst  in  1  1 = 16-word read burst; ignored on writes.
sdram_wstrb  in  4  byte enables for a write.
sdram_wdata  in  32  write data; ignored on reads.
sdram_raddress  out  26  byte address of the returned word, bits [1:0] = 0.
sdram_rdata  out  32  returned read data.
sdram_rvalid  out  3  ID of the master owning the returned word; 0 means no data.
sdram_complete  out  1  high with the last word of a read transaction.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: ready=0, rvalid=0, complete=0, raddress=0, rdata=0, state=IDLE. RAM contents are not cleared.
- ready is registered. It goes to 1 on the first clk edge after reset_n deasserts, and stays 1 while in IDLE.
- Accept: a request is accepted in any cycle with ready=1 and request!=0.
  - ID, address, write, burst, wstrb and wdata are captured on that edge, and ready goes to 0 on the same edge.
  - The arbiter presents its next request in the following cycle; the responder does not look at it until ready returns to 1.
- FSM states: IDLE, WRITE, WAIT, READ.
- Write:
  - IDLE -> WRITE on accept. The RAM is written in the WRITE cycle, byte-wise per wstrb.
  - WRITE -> IDLE; ready=1 again 2 cycles after the accept cycle.
  - No rvalid is produced. wstrb=0 consumes the request with no RAM change.
- Read timing:
  - IDLE -> WAIT on accept. A counter runs so that the first rvalid appears exactly READ_LATENCY cycles after the accept cycle.
  - WAIT -> READ issues synchronous RAM reads, one word per cycle.
  - Data, rvalid, raddress and complete are registered outputs, valid on consecutive cycles with no gaps.
- Single read: exactly one word, with complete=1.
- Burst read: 16 words.
  - Order is critical-word-first, starting at address[5:2] and wrapping within the aligned 64-byte line.
  - raddress[25:6] is held; raddress[5:2] = (start+k) mod 16.
  - complete=1 only on the 16th word.
- Return to IDLE: ready returns to 1 the cycle after the last rvalid, so back-to-back requests are never overlapped.
- rvalid echoes the captured ID unchanged, including IDs 6 and 7.
- Outside an rvalid cycle: complete=0 and rvalid=0; rdata/raddress hold their last value.
- Read-after-write to the same address returns the new data, since the write completes before the next accept.
- Reset mid-burst (reset_n low): outputs drop to reset values immediately (asynchronous), and the remaining words are never sent. The RAM keeps any write already performed.
- request=0 while ready=1: no state change.

Decomposition:
- Package sdram_pkg holds:
  - SDRAM_ID_W=3 and SDRAM_ADDR_W=26;
  - BURST_WORDS=16;
  - the responder state enum (IDLE, WRITE, WAIT, READ);
  - the typedef for the captured request struct (id, addr, write, burst, wstrb, wdata).
- One sub-module: bram_bytewise, a single-port RAM with synchronous read and 4 byte-write enables, parameterised by depth, so it infers block RAM.
- FSM, latency counter and burst word counter stay in the top module.

Test Plan:
- Write ID=1, addr 0x000100, wdata 0xDEADBEEF, wstrb 1111, then single read ID=2 from 0x000100 -> one cycle with rvalid=2, rdata 0xDEADBEEF, raddress 0x000100, complete=1, exactly 4 cycles after the read accept.
- Write 0x11223344 to 0x200, then write 0xAABBCCDD with wstrb 0101, then read -> rdata 0x11BB33DD.
- Fill the line at 0x400 with word i = i, then burst read ID=3 from 0x428 (word 10) -> 16 consecutive rvalid=3 cycles.
  - Data order 10..15, 0..9; raddress 0x428..0x43C, 0x400..0x424.
  - complete high only on the word at 0x424.
- Back-to-back requests from the arbiter, with m1 and m5 both pending -> ready low for the full first transaction.
  - The second request is accepted only on the cycle after the last rvalid.
  - Responses never overlap and IDs 1 then 5 are echoed.
- Assert reset_n low after the 5th burst word -> rvalid=0, complete=0 and ready=0 immediately.
  - After release, ready=1 one edge later.
  - A single read of a previously written word still returns the correct data.
- Address aliasing: write 0xCAFEF00D to word 0 and read back from byte address (1<<(ADDR_WORDS_LOG2+2)) -> rdata 0xCAFEF00D.
